button_in: RTL
==============

Name: button_in

Overview:
- Input-side GPIO peripheral. It brings raw asynchronous push-button/switch lines into the clock domain, debounces them, and detects edges.
- Each bit has a sticky, write-1-to-clear event flag and a maskable interrupt request for the CPU core.
- It is the input counterpart to the 7-bit LED output driver and sits on the same SoC peripheral side. Its default width matches the LED port.

Parameters:
- WIDTH, 7, number of independent input lines.
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles required before a level change is accepted. Must be >= 1.
- SYNC_STAGES, 2, synchronizer flop depth per line. Must be >= 2.

Ports:
- clk_i  input  1  system clock.
- rst_i  input  1  synchronous active-high reset.
- btn_i  input  WIDTH  raw asynchronous button/switch lines, active-high.
- mask_i  input  WIDTH  per-bit interrupt enable; 1 = enabled.
- clr_i  input  WIDTH  write-1-to-clear strobe for event_o bits; single-cycle or held.
- level_o  output  WIDTH  debounced level per line.
- rise_o  output  WIDTH  one-cycle pulse on each debounced 0->1 transition.
- fall_o  output  WIDTH  one-cycle pulse on each debounced 1->0 transition.
- event_o  output  WIDTH  sticky pending flags, set by a debounced rising edge.
- irq_o  output  1  OR-reduction of (event_o & mask_i), combinational.

Behaviour:
- Reset (rst_i=1 at a clk_i edge): clears all synchronizer flops, debounce counters, level_o, rise_o, fall_o and event_o to 0.
  - irq_o is therefore 0.
  - Reset mid-debounce discards the partial count.
  - Reset overrides clr_i and any edge in the same cycle.
- Synchronizer: a SYNC_STAGES-deep flop chain per bit. sync[i] denotes the last stage.
- Debounce: one counter per bit, width $clog2(DEBOUNCE_CYCLES+1).
  - If sync[i] == level_o[i]: the counter goes to 0.
  - If sync[i] != level_o[i] and the counter < DEBOUNCE_CYCLES-1: the counter increments.
  - If sync[i] != level_o[i] and the counter == DEBOUNCE_CYCLES-1: level_o[i] <= sync[i] and the counter goes to 0.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles (after sync) restarts the count and never reaches level_o.
  - The counter never wraps.
- Latency: after btn_i changes and then stays stable, level_o updates at the (SYNC_STAGES + DEBOUNCE_CYCLES)-th rising clk_i edge. The first edge counts as 1.
  - Example: SYNC_STAGES=2, DEBOUNCE_CYCLES=4 gives 6 edges.
- Edge pulses: rise_o/fall_o are registered and asserted for exactly one cycle, in the same cycle level_o shows the new value. They are never both set for the same bit.
- Event flags: per bit, evaluated in this priority order:
  - set by rise_o condition (next-state of level_o going 0->1), visible in the same cycle as rise_o;
  - else cleared if clr_i[i]=1;
  - else hold.
  - Simultaneous set and clear: set wins, so the flag stays 1.
  - Falling edges do not affect event_o.
- Bits are fully independent. Any number may change, debounce, and set events in the same cycle.
- irq_o: combinational from registered event_o and mask_i.
  - Masked events still latch in event_o.
  - Unmasking later raises irq_o immediately.
- Power-on case: a line held high through reset is accepted after the full latency and produces rise_o and event_o like any press.

Test Plan (DEBOUNCE_CYCLES=4, SYNC_STAGES=2, WIDTH=7):
- Clean press: rst 2 cycles, then btn_i=7'h01 held -> level_o[0]=1 and rise_o=7'h01 for one cycle at edge 6; event_o=7'h01 from edge 6; irq_o=1 with mask_i=7'h7F.
- Glitch rejection: btn_i[1] pulses high for 3 cycles then low -> level_o, rise_o, event_o stay 0. A 4-cycle-stable pulse (after sync) is accepted.
- Release/clear: with bit 0 pressed and latched, set btn_i=0 -> fall_o=7'h01 one cycle; event_o stays 7'h01. Then clr_i=7'h01 for one cycle -> event_o=0 next edge, irq_o=0.
- Set-vs-clear collision: hold clr_i=7'h04 while btn_i[2] debounces high -> at the rise cycle event_o[2]=1 and it remains 1. It clears on the first clr_i[2]=1 cycle after.
- Masking and parallelism: btn_i=7'h50 with mask_i=7'h10 -> event_o=7'h50, irq_o=1. With mask_i=7'h00, irq_o=0 and event_o unchanged. Set mask_i=7'h40 -> irq_o=1 same cycle.
- Reset mid-operation: assert rst_i during a debounce count and with event_o=7'h7F -> all outputs 0 next edge; a held input then takes the full 6-edge latency again after release of reset.

Source files
------------

// File: rtl/button_in.sv
// Push-button / switch input block: synchronizes raw lines, debounces them,
// produces one-cycle edge pulses and sticky write-1-to-clear press events
// with a maskable interrupt request.
module button_in #(
  parameter int unsigned WIDTH           = 7,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] btn_i,
  input  logic [WIDTH-1:0] mask_i,
  input  logic [WIDTH-1:0] clr_i,
  output logic [WIDTH-1:0] level_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic [WIDTH-1:0] event_o,
  output logic             irq_o
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  // Last count before acceptance; the acceptance edge itself is the D-th
  // differing sample.
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [CntW-1:0]  cnt_q  [WIDTH];
  logic [CntW-1:0]  cnt_d  [WIDTH];
  logic [WIDTH-1:0] sync_last;
  logic [WIDTH-1:0] level_q, level_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic [WIDTH-1:0] event_q, event_d;

  assign sync_last = sync_q[SYNC_STAGES-1];

  // Synchronizer chain: first stage samples the asynchronous pins.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
    end else begin
      sync_q[0] <= btn_i;
      for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  // Per-bit debounce: count consecutive disagreeing samples, accept on the last one.
  always_comb begin
    level_d = level_q;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync_last[i] != level_q[i]) begin
        if (cnt_q[i] == CntLast) begin
          level_d[i] = sync_last[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CntW'(1);
        end
      end
    end
  end

  // Edge pulses and sticky events; a new press beats a simultaneous clear.
  always_comb begin
    rise_d  = level_d & ~level_q;
    fall_d  = ~level_d & level_q;
    event_d = rise_d | (event_q & ~clr_i);
  end

  // Debounce and output state registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
      level_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      event_q <= '0;
    end else begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      event_q <= event_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
  assign event_o = event_q;
  assign irq_o   = |(event_q & mask_i);

endmodule
